sort_floats_oets: RTL and testbench



---
 rtl/sort_floats_oets_if.sv | 13 +
 rtl/sort_floats_oets.sv | 101 ++++++++++
 tb/tb_sort_floats_oets.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sort_floats_oets_if.sv
// sort_floats_oets_if: vector handshake bundle between the producer/consumer (master) and the sorter (slave).
interface sort_floats_oets_if #(parameter int N = 8);
  localparam int FLEN = 64;
  logic                     up_valid;
  logic                     up_ready;
  logic [0:N-1][FLEN-1:0]   up_data;
  logic                     down_valid;
  logic                     down_ready;
  logic [0:N-1][FLEN-1:0]   down_data;
  logic                     down_err;
  modport master (output up_valid, up_data, down_ready, input up_ready, down_valid, down_data, down_err);
  modport slave  (input up_valid, up_data, down_ready, output up_ready, down_valid, down_data, down_err);
endinterface

// File: rtl/sort_floats_oets.sv
// sort_floats_oets: N-element odd-even transposition float sorter; SORT_FLOATS_OETS_EARLY_EXIT_EN ends after two swap-free phases.
module f_less_or_equal #(parameter int FLEN = 64) (
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  output logic            res_o,
  output logic            err_o
);
  localparam int EW = (FLEN == 32) ? 8 : 11;
  logic a_nan, b_nan, zeros, a_s, b_s;
  logic [FLEN-2:0] a_m, b_m;
  assign a_s = a_i[FLEN-1];
  assign b_s = b_i[FLEN-1];
  assign a_m = a_i[FLEN-2:0];
  assign b_m = b_i[FLEN-2:0];
  assign a_nan = (&a_m[FLEN-2 -: EW]) && (|a_m[FLEN-EW-2:0]);
  assign b_nan = (&b_m[FLEN-2 -: EW]) && (|b_m[FLEN-EW-2:0]);
  assign zeros = ~|{a_m, b_m};
  assign err_o = a_nan | b_nan;
  // sign-magnitude order; +0 and -0 compare equal
  assign res_o = !err_o && (zeros || ((a_s != b_s) ? a_s : (a_s ? (a_m >= b_m) : (a_m <= b_m))));
endmodule

module sort_floats_oets #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  sort_floats_oets_if.slave io
);
  localparam int FLEN = 64;
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  state_t                 state_q;
  logic [0:N-1][FLEN-1:0] r_q, r_d;
  logic [PW-1:0]          phase_q;
  logic                   err_q, err_d, up_ready_q, down_valid_q, last;
  logic [N-2:0]           res, cerr, swap;
  for (genvar g = 0; g < N-1; g++) begin : g_cmp
    f_less_or_equal #(.FLEN(FLEN)) u_cmp (.a_i(r_q[g]), .b_i(r_q[g+1]), .res_o(res[g]), .err_o(cerr[g]));
  end
  // pair i is active when its parity matches the phase parity
  always_comb begin
    r_d = r_q;
    err_d = 1'b0;
    swap = '0;
    for (int i = 0; i < N-1; i++) begin
      swap[i] = (i[0] == phase_q[0]) && !res[i];
      err_d = err_d | ((i[0] == phase_q[0]) && cerr[i]);
      if (swap[i]) begin
        r_d[i] = r_q[i+1];
        r_d[i+1] = r_q[i];
      end
    end
  end
`ifdef SORT_FLOATS_OETS_EARLY_EXIT_EN
  logic quiet_q;
  assign last = (phase_q == PW'(N-1)) || (quiet_q && !(|swap));
  always_ff @(posedge clk or posedge rst)
    if (rst) quiet_q <= 1'b0;
    else quiet_q <= (state_q == SORT) && !(|swap);
`else
  assign last = phase_q == PW'(N-1);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q <= '0;
      phase_q <= '0;
      err_q <= 1'b0;
      up_ready_q <= 1'b1;
      down_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.up_valid) begin
          r_q <= io.up_data;
          err_q <= 1'b0;
          phase_q <= '0;
          up_ready_q <= 1'b0;
          state_q <= SORT;
        end
        SORT: begin
          r_q <= r_d;
          err_q <= err_q | err_d;
          phase_q <= phase_q + 1'b1;
          if (last) begin
            down_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (io.down_ready) begin
          down_valid_q <= 1'b0;
          up_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign io.up_ready = up_ready_q;
  assign io.down_valid = down_valid_q;
  assign io.down_data = r_q;
  assign io.down_err = err_q;
endmodule

// File: tb/tb_sort_floats_oets.sv
// tb_sort_floats_oets: directed scoreboard bench for the odd-even transposition sorter.
module tb_sort_floats_oets;
  localparam int N = 8;
  typedef logic [0:N-1][63:0] vec_t;
  typedef struct {vec_t in; vec_t exp; int lat; bit nan;} exp_t;
`ifdef SORT_FLOATS_OETS_EARLY_EXIT_EN
  localparam int LAT_SORTED = 2;
  localparam int LAT_VAR = -1;
`else
  localparam int LAT_SORTED = N;
  localparam int LAT_VAR = N;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  sort_floats_oets_if #(.N(N)) bus();
  sort_floats_oets #(.N(N)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    logic [63:0] key;
    int j;
    for (int i = 1; i < N; i++) begin
      key = v[i];
      j = i - 1;
      while (j >= 0 && $bitstoreal(v[j]) > $bitstoreal(key)) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = key;
    end
    return v;
  endfunction

  function automatic vec_t bsort(input vec_t v);
    logic [63:0] t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N-1-i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v;
  endfunction

  task automatic send(input vec_t v, input bit push, input int lat, input bit nan);
    exp_t e;
    @(negedge clk);
    check("up_ready_before", bus.up_ready, 1);
    bus.up_valid = 1'b1;
    bus.up_data = v;
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    check("up_ready_after_accept", bus.up_ready, 0);
    if (push) begin
      e.in = v; e.exp = model(v); e.lat = lat; e.nan = nan;
      sb.push_back(e);
    end
  endtask

  task automatic recv();
    exp_t e;
    vec_t a, b;
    int cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!bus.down_valid && cnt < 40);
    check("down_valid", bus.down_valid, 1);
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.lat < 0) check("latency_range", cnt >= 2 && cnt <= N, 1);
      else check("latency", cnt, e.lat);
      check("down_err", bus.down_err, e.nan);
      if (e.nan) begin
        a = bsort(bus.down_data);
        b = bsort(e.in);
        for (int i = 0; i < N; i++) check($sformatf("perm[%0d]", i), a[i], b[i]);
      end else
        for (int i = 0; i < N; i++) check($sformatf("data[%0d]", i), bus.down_data[i], e.exp[i]);
    end
  endtask

  task automatic release_out();
    bus.down_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.down_ready = 1'b0;
    check("idle_up_ready", bus.up_ready, 1);
    check("idle_down_valid", bus.down_valid, 0);
  endtask

  initial begin
    vec_t v, held;
    real dv[N];
    int k;
    bus.up_valid = 1'b0;
    bus.up_data = '0;
    bus.down_ready = 1'b0;
    #12;
    check("rst_up_ready", bus.up_ready, 1);
    check("rst_down_valid", bus.down_valid, 0);
    check("rst_down_err", bus.down_err, 0);
    check("rst_data0", bus.down_data[0], 0);
    @(negedge clk);
    rst = 1'b0;
    // reversed 8.0..1.0
    for (int i = 0; i < N; i++) v[i] = $realtobits(8.0 - i);
    send(v, 1, LAT_VAR, 0);
    recv();
    release_out();
    // already sorted
    dv = '{-1.0, 0.5, 1.0, 2.0, 3.0, 4.0, 5.0, 6.0};
    for (int i = 0; i < N; i++) v[i] = $realtobits(dv[i]);
    send(v, 1, LAT_SORTED, 0);
    recv();
    release_out();
    // duplicates tagged in input order in the LSB
    dv = '{2.0, 1.0, 2.0, -1.0, 1.0, 0.5, 2.0, 0.5};
    for (int i = 0; i < N; i++) begin
      k = 0;
      for (int j = 0; j < i; j++) if (dv[j] == dv[i]) k++;
      v[i] = $realtobits(dv[i]) + 64'(k);
    end
    send(v, 1, LAT_VAR, 0);
    recv();
    release_out();
    // signed zeros compare equal, so input order must survive
    v = '{64'h0, 64'h8000000000000000, 64'h3FF0000000000000, 64'h8000000000000000,
          64'h0, 64'hBFF0000000000000, 64'h8000000000000000, 64'h0};
    send(v, 1, LAT_VAR, 0);
    recv();
    release_out();
    // qNaN in slot 3
    for (int i = 0; i < N; i++) v[i] = $realtobits(8.0 - i);
    v[3] = 64'h7FF8000000000000;
    send(v, 1, LAT_VAR, 1);
    recv();
    // hold output with down_ready low while up_valid pulses
    held = bus.down_data;
    for (int c = 0; c < 5; c++) begin
      bus.up_valid = c[0];
      bus.up_data = '1;
      @(posedge clk);
      #1;
      check("hold_valid", bus.down_valid, 1);
      check("hold_up_ready", bus.up_ready, 0);
      check("hold_data", bus.down_data == held, 1);
    end
    bus.up_valid = 1'b0;
    release_out();
    check("no_capture", bus.down_data == held, 1);
    // async reset during phase 3
    for (int i = 0; i < N; i++) v[i] = $realtobits(1.5 * (N - i));
    send(v, 0, LAT_VAR, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_down_valid", bus.down_valid, 0);
    check("arst_up_ready", bus.up_ready, 1);
    check("arst_data0", bus.down_data[0], 0);
    @(negedge clk);
    rst = 1'b0;
    send(v, 1, LAT_VAR, 0);
    recv();
    release_out();
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
